// File: rtl/gouram_datatypes.sv
// Shared types and constants for the gouram/kuuga trace and AXI read masters.
package gouram_datatypes;

  localparam logic [6:0] OPC_LOAD       = 7'b0000011;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef struct packed {
    logic        valid;
    logic        is_load;
    logic        hit;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] daddr;
    logic [31:0] ddata;
  } trace_format;

endpackage

// File: rtl/kuuga_sc_dm_wrapper_pkg.sv
// Local types and helpers for the kuuga single-cycle trace wrapper.
package kuuga_sc_dm_wrapper_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_AR,
    S_FETCH_R,
    S_DECODE,
    S_LOOKUP,
    S_MISS_AR,
    S_MISS_R,
    S_EMIT
  } state_e;

  // Word-aligned data address of a load: base plus the zero-extended 12-bit immediate.
  function automatic logic [31:0] load_addr(input logic [31:0] base, input logic [11:0] imm);
    return (base + {20'd0, imm}) & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/kuuga_sc_dm_wrapper_dm_cache_array.sv
// Direct-mapped word cache: tag/valid/data arrays with a combinational hit and read port.
module dm_cache_array #(
  parameter int NUM_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] waddr_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  output logic        hit_o,
  output logic [31:0] rd_data_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  assign idx = waddr_i[IDX_W-1:0];
  assign tag = waddr_i[29 -: TAG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= wr_data_i;
    end
  end

  assign hit_o     = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_data_o = data_q[idx];

endmodule

// File: rtl/kuuga_sc_dm_wrapper.sv
// Fetch/decode walker that replays loads through a direct-mapped cache and emits one trace record per word.
module kuuga_sc_dm_wrapper
  import gouram_datatypes::*;
  import kuuga_sc_dm_wrapper_pkg::*;
#(
  parameter int          NUM_LINES = 64,
  parameter logic [31:0] DATA_BASE = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output trace_format trace_data_o,
  output logic [2:0]  state_o,
  // Both read channels: a transfer completes on the rising edge where valid && ready are
  // both high; ar* stays stable until then and rready is high only while awaiting that R beat.
  output logic [31:0] im_araddr,
  output logic        im_arvalid,
  output logic [7:0]  im_arlen,
  output logic [2:0]  im_arsize,
  output logic [1:0]  im_arburst,
  input  logic        im_arready,
  input  logic [31:0] im_rdata,
  input  logic [1:0]  im_rresp,
  input  logic        im_rlast,
  input  logic        im_rvalid,
  output logic        im_rready,
  output logic [31:0] dm_araddr,
  output logic        dm_arvalid,
  output logic [7:0]  dm_arlen,
  output logic [2:0]  dm_arsize,
  output logic [1:0]  dm_arburst,
  input  logic        dm_arready,
  input  logic [31:0] dm_rdata,
  input  logic [1:0]  dm_rresp,
  input  logic        dm_rlast,
  input  logic        dm_rvalid,
  output logic        dm_rready
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  trace_format trace_q, trace_d;

  logic [31:0] daddr;
  logic        is_load;
  logic        cache_we;
  logic        cache_hit;
  logic [31:0] cache_rdata;
  logic        unused_axi;

  assign daddr      = load_addr(DATA_BASE, instr_q[31:20]);
  assign is_load    = (instr_q[6:0] == OPC_LOAD);
  assign unused_axi = ^{im_rresp, im_rlast, dm_rresp, dm_rlast};

  dm_cache_array #(
    .NUM_LINES (NUM_LINES)
  ) u_cache (
    .clk       (clk),
    .rst       (rst_n),
    .waddr_i   (daddr[31:2]),
    .wr_en_i   (cache_we),
    .wr_data_i (dm_rdata),
    .hit_o     (cache_hit),
    .rd_data_o (cache_rdata)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      trace_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      trace_q <= trace_d;
    end
  end

  // The record is loaded on the edge that enters EMIT, so valid is high exactly for that state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    trace_d       = trace_q;
    trace_d.valid = 1'b0;
    cache_we      = 1'b0;
    case (state_q)
      S_IDLE:     state_d = S_FETCH_AR;
      S_FETCH_AR: if (im_arready) state_d = S_FETCH_R;
      S_FETCH_R: begin
        if (im_rvalid) begin
          instr_d = im_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_load) begin
          state_d = S_LOOKUP;
        end else begin
          state_d = S_EMIT;
          trace_d = '{valid: 1'b1, is_load: 1'b0, hit: 1'b0, pc: pc_q, instr: instr_q,
                      daddr: 32'd0, ddata: 32'd0};
        end
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          state_d = S_EMIT;
          trace_d = '{valid: 1'b1, is_load: 1'b1, hit: 1'b1, pc: pc_q, instr: instr_q,
                      daddr: daddr, ddata: cache_rdata};
        end else begin
          state_d = S_MISS_AR;
        end
      end
      S_MISS_AR:  if (dm_arready) state_d = S_MISS_R;
      S_MISS_R: begin
        if (dm_rvalid) begin
          cache_we = 1'b1;
          state_d  = S_EMIT;
          trace_d  = '{valid: 1'b1, is_load: 1'b1, hit: 1'b0, pc: pc_q, instr: instr_q,
                       daddr: daddr, ddata: dm_rdata};
        end
      end
      S_EMIT: begin
        pc_d    = pc_q + 32'd4;
        state_d = S_FETCH_AR;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  assign trace_data_o = trace_q;
  assign state_o      = state_q;

  assign im_araddr  = pc_q;
  assign im_arvalid = (state_q == S_FETCH_AR);
  assign im_arlen   = AXI_LEN_SINGLE;
  assign im_arsize  = AXI_SIZE_WORD;
  assign im_arburst = AXI_BURST_INCR;
  assign im_rready  = (state_q == S_FETCH_R);

  assign dm_araddr  = daddr;
  assign dm_arvalid = (state_q == S_MISS_AR);
  assign dm_arlen   = AXI_LEN_SINGLE;
  assign dm_arsize  = AXI_SIZE_WORD;
  assign dm_arburst = AXI_BURST_INCR;
  assign dm_rready  = (state_q == S_MISS_R);

endmodule

// File: tb/tb_kuuga_sc_dm_wrapper.sv
// Randomized bench for kuuga_sc_dm_wrapper: AXI slave models, a program-order cache model and a record scoreboard.
module tb_kuuga_sc_dm_wrapper;
  import gouram_datatypes::*;

  localparam int          NUM_LINES = 64;
  localparam logic [31:0] DATA_BASE = 32'h0010_0000;
  localparam int          TW        = $bits(trace_format);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  trace_format trace_data_o;
  logic [2:0]  state_dbg;
  logic [31:0] im_araddr, im_rdata, dm_araddr, dm_rdata;
  logic        im_arvalid, im_arready, im_rlast, im_rvalid, im_rready;
  logic        dm_arvalid, dm_arready, dm_rlast, dm_rvalid, dm_rready;
  logic [7:0]  im_arlen, dm_arlen;
  logic [2:0]  im_arsize, dm_arsize;
  logic [1:0]  im_arburst, dm_arburst, im_rresp, dm_rresp;

  kuuga_sc_dm_wrapper #(.NUM_LINES(NUM_LINES), .DATA_BASE(DATA_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .trace_data_o(trace_data_o), .state_o(state_dbg),
    .im_araddr(im_araddr), .im_arvalid(im_arvalid), .im_arlen(im_arlen), .im_arsize(im_arsize),
    .im_arburst(im_arburst), .im_arready(im_arready), .im_rdata(im_rdata), .im_rresp(im_rresp),
    .im_rlast(im_rlast), .im_rvalid(im_rvalid), .im_rready(im_rready),
    .dm_araddr(dm_araddr), .dm_arvalid(dm_arvalid), .dm_arlen(dm_arlen), .dm_arsize(dm_arsize),
    .dm_arburst(dm_arburst), .dm_arready(dm_arready), .dm_rdata(dm_rdata), .dm_rresp(dm_rresp),
    .dm_rlast(dm_rlast), .dm_rvalid(dm_rvalid), .dm_rready(dm_rready)
  );

  // ---------------- scoreboard state ----------------
  int              errors = 0;
  int              checks = 0;
  logic [TW-1:0]   exp_q[$];
  int              exp_cnt_q[$];
  trace_format     rec_log[$];
  logic [31:0]     imem [int];
  int              im_hold_fixed = -1;
  int              dm_r_fixed = -1;
  int              dm_ar_count = 0;
  logic [31:0]     dm_last_araddr = '0;
  int              im_r_cycle = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dmem_word(input logic [31:0] a);
    if (a == 32'h0010_0004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] get_instr(input logic [31:0] pc);
    if (imem.exists(int'(pc))) return imem[int'(pc)];
    return 32'h0000_0013;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) < 6) begin
      case ($urandom_range(0, 4))
        0: w[31:20] = 12'h004;
        1: w[31:20] = 12'h104;
        2: w[31:20] = 12'h008;
        3: w[31:20] = 12'h0FD;
        default: ;
      endcase
      w[6:0] = 7'b0000011;
    end else if (w[6:0] == 7'b0000011) begin
      w[6:0] = 7'b0010011;
    end
    return w;
  endfunction

  // Reference: walk the program in order, keeping the address held by each cache line.
  task automatic build_expected(input int n);
    logic [31:0] line_addr [int];
    trace_format rec;
    logic [31:0] w, a;
    int          idx, misses;
    exp_q.delete();
    exp_cnt_q.delete();
    misses = 0;
    for (int i = 0; i < n; i++) begin
      w = get_instr(32'(i * 4));
      rec = '0;
      rec.valid = 1'b1;
      rec.pc    = 32'(i * 4);
      rec.instr = w;
      if (w[6:0] == 7'b0000011) begin
        a = DATA_BASE + {20'd0, w[31:20]};
        a[1:0] = 2'b00;
        idx = int'(a >> 2) % NUM_LINES;
        rec.is_load = 1'b1;
        rec.daddr   = a;
        rec.ddata   = dmem_word(a);
        if (line_addr.exists(idx) && line_addr[idx] == a) begin
          rec.hit = 1'b1;
        end else begin
          misses++;
          line_addr[idx] = a;
        end
      end
      exp_q.push_back(rec);
      exp_cnt_q.push_back(misses);
    end
  endtask

  // ---------------- instruction-port slave ----------------
  initial begin : im_slave
    int          hold, rwait;
    bit          pend, in_req, ar_fire, r_fire;
    logic [31:0] req_addr, raddr;
    im_arready = 1'b0; im_rvalid = 1'b0; im_rdata = '0; im_rresp = 2'b00; im_rlast = 1'b1;
    hold = 0; rwait = 0; pend = 0; in_req = 0; ar_fire = 0; r_fire = 0; req_addr = '0; raddr = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        im_arready = 1'b0; im_rvalid = 1'b0; pend = 0; in_req = 0; ar_fire = 0; r_fire = 0;
        continue;
      end
      if (in_req && !ar_fire) check_eq("im_ar_stable", {im_arvalid, im_araddr}, {1'b1, req_addr});
      if (ar_fire) begin
        in_req = 0; pend = 1; raddr = req_addr; rwait = $urandom_range(0, 2); im_arready = 1'b0;
      end
      if (r_fire) begin
        im_rvalid = 1'b0; pend = 0;
      end
      if (!pend && !in_req && im_arvalid) begin
        in_req = 1; req_addr = im_araddr;
        hold = (im_hold_fixed >= 0) ? im_hold_fixed : $urandom_range(0, 3);
        check_eq("im_ar_attr", {im_arlen, im_arsize, im_arburst}, {8'h00, 3'd2, 2'b01});
      end
      if (in_req) begin
        if (hold == 0) im_arready = 1'b1;
        else begin hold--; im_arready = 1'b0; end
      end
      if (pend && !im_rvalid) begin
        if (rwait == 0) begin im_rvalid = 1'b1; im_rdata = get_instr(raddr); end
        else rwait--;
      end
      ar_fire = im_arvalid && im_arready;
      r_fire  = im_rvalid && im_rready;
      if (r_fire) im_r_cycle = cyc + 1;
    end
  end

  // ---------------- data-port slave ----------------
  initial begin : dm_slave
    int          hold, rwait;
    bit          pend, in_req, ar_fire, r_fire;
    logic [31:0] req_addr, raddr;
    dm_arready = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0; dm_rresp = 2'b00; dm_rlast = 1'b1;
    hold = 0; rwait = 0; pend = 0; in_req = 0; ar_fire = 0; r_fire = 0; req_addr = '0; raddr = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        dm_arready = 1'b0; dm_rvalid = 1'b0; pend = 0; in_req = 0; ar_fire = 0; r_fire = 0;
        continue;
      end
      if (in_req && !ar_fire) check_eq("dm_ar_stable", {dm_arvalid, dm_araddr}, {1'b1, req_addr});
      if (ar_fire) begin
        in_req = 0; pend = 1; raddr = req_addr; dm_arready = 1'b0;
        rwait = (dm_r_fixed >= 0) ? dm_r_fixed : $urandom_range(0, 3);
        dm_ar_count++;
        dm_last_araddr = req_addr;
      end
      if (r_fire) begin
        dm_rvalid = 1'b0; pend = 0;
      end
      if (!pend && !in_req && dm_arvalid) begin
        in_req = 1; req_addr = dm_araddr; hold = $urandom_range(0, 3);
        check_eq("dm_ar_attr", {dm_arlen, dm_arsize, dm_arburst}, {8'h00, 3'd2, 2'b01});
      end
      if (in_req) begin
        if (hold == 0) dm_arready = 1'b1;
        else begin hold--; dm_arready = 1'b0; end
      end
      if (pend && !dm_rvalid) begin
        if (rwait == 0) begin dm_rvalid = 1'b1; dm_rdata = dmem_word(raddr); end
        else rwait--;
      end
      ar_fire = dm_arvalid && dm_arready;
      r_fire  = dm_rvalid && dm_rready;
    end
  end

  // ---------------- record monitor ----------------
  initial begin : monitor
    logic [TW-1:0] last_rec;
    trace_format   exp_rec;
    int            exp_cnt;
    bit            prev_valid;
    last_rec = '0; prev_valid = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        last_rec = '0; prev_valid = 0;
        continue;
      end
      if (trace_data_o.valid) begin
        check_eq("valid_pulse", prev_valid, 1'b0);
        rec_log.push_back(trace_data_o);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_record", trace_data_o, '0);
        end else begin
          exp_rec = exp_q.pop_front();
          exp_cnt = exp_cnt_q.pop_front();
          check_eq("record", trace_data_o, exp_rec);
          check_eq("dm_ar_count", dm_ar_count, exp_cnt);
          if (exp_rec.is_load && !exp_rec.hit) check_eq("dm_araddr", dm_last_araddr, exp_rec.daddr);
          if (!exp_rec.is_load) check_eq("nonload_latency", cyc - im_r_cycle, 1);
          else if (exp_rec.hit) check_eq("hit_latency", cyc - im_r_cycle, 2);
        end
        last_rec = trace_data_o;
      end else begin
        check_eq("idle_fields", trace_data_o, {1'b0, last_rec[TW-2:0]});
      end
      prev_valid = trace_data_o.valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold_reset(input int cycles);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 check_eq("rst_outputs", {trace_data_o, im_arvalid, im_rready, dm_arvalid, dm_rready}, '0);
    dm_ar_count = 0;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_eq("idle_after_release", im_arvalid, 1'b0);
    @(negedge clk);
    check_eq("first_fetch", {im_arvalid, im_araddr}, {1'b1, 32'h0});
  endtask

  task automatic run_program(input int n, input string name);
    build_expected(n);
    rec_log.delete();
    release_reset();
    for (int c = 0; c < n * 80 && exp_q.size() > 0; c++) @(negedge clk);
    if (exp_q.size() != 0) $display("note: %s stalled in state %0d", name, state_dbg);
    check_eq({name, "_drained"}, exp_q.size(), 0);
    hold_reset(2);
  endtask

  task automatic fill_random(input int from_pc, input int n);
    for (int i = 0; i < n; i++) imem[from_pc + 4 * i] = rand_word();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst_n = 1'b1;
    hold_reset(3);
    @(negedge clk);
    check_eq("reset_trace", trace_data_o, '0);

    // Miss, hit, eviction pair, non-load, then random traffic.
    imem.delete();
    imem[0]  = 32'h0040_0003;
    imem[4]  = 32'h0040_0003;
    imem[8]  = 32'h1040_0003;
    imem[12] = 32'h0040_0003;
    imem[16] = 32'h0000_0013;
    fill_random(20, 30);
    run_program(35, "directed");
    check_eq("directed_count", rec_log.size(), 35);
    if (rec_log.size() >= 5) begin
      check_eq("rec0", {rec_log[0].is_load, rec_log[0].hit, rec_log[0].pc, rec_log[0].daddr, rec_log[0].ddata},
               {1'b1, 1'b0, 32'h0, 32'h0010_0004, 32'hDEAD_BEEF});
      check_eq("rec1", {rec_log[1].hit, rec_log[1].pc, rec_log[1].ddata}, {1'b1, 32'h4, 32'hDEAD_BEEF});
      check_eq("rec2", {rec_log[2].hit, rec_log[2].daddr}, {1'b0, 32'h0010_0104});
      check_eq("rec3", {rec_log[3].hit, rec_log[3].daddr, rec_log[3].ddata}, {1'b0, 32'h0010_0004, 32'hDEAD_BEEF});
      check_eq("rec4", {rec_log[4].is_load, rec_log[4].hit, rec_log[4].daddr, rec_log[4].ddata}, '0);
    end

    // Instruction arready held low for 10 cycles on every fetch.
    imem.delete();
    fill_random(0, 6);
    imem[0] = 32'h0000_0013;
    im_hold_fixed = 10;
    run_program(6, "ar_hold");
    im_hold_fixed = -1;

    // Reset while the data read is outstanding, then restart from pc 0.
    imem.delete();
    imem[0] = 32'h0040_0003;
    imem[4] = 32'h0040_0003;
    imem[8] = 32'h0000_0013;
    build_expected(0);
    dm_r_fixed = 30;
    release_reset();
    for (int c = 0; c < 100 && dm_ar_count == 0; c++) @(negedge clk);
    check_eq("abort_miss_ar", dm_ar_count, 1);
    repeat (2) @(negedge clk);
    check_eq("abort_in_miss_r", {dm_rready, trace_data_o.valid}, {1'b1, 1'b0});
    hold_reset(2);
    dm_r_fixed = -1;
    run_program(3, "restart");
    check_eq("restart_count", rec_log.size(), 3);
    if (rec_log.size() >= 2) begin
      check_eq("restart_first_miss", {rec_log[0].pc, rec_log[0].hit, rec_log[0].ddata}, {32'h0, 1'b0, 32'hDEAD_BEEF});
      check_eq("restart_second_hit", rec_log[1].hit, 1'b1);
    end

    // Longer random run.
    imem.delete();
    fill_random(0, 60);
    run_program(60, "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
